// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the even clock divider and its period checker.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } chk_state_t;

  localparam int CNT_W_DEF      = 8;
  localparam int LOCK_COUNT_DEF = 4;

endpackage

// File: rtl/edge_detect_1b.sv
// One-bit registered edge detector: reports rise/fall of d against its previous sample.
module edge_detect_1b (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall,
  output logic d_q
);

  // previous-sample register
  always_ff @(posedge clk) begin
    if (reset) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/div_clk_period_checker.sv
// Measures high/low phases of a divided clock on the fast clock, flags mismatches
// against the expected half period and declares lock after consecutive good periods.
module div_clk_period_checker
  import clk_div_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int LOCK_COUNT = LOCK_COUNT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             div_in,
  input  logic [CNT_W-1:0] half_period,
  output logic [CNT_W:0]   period_out,
  output logic             period_valid,
  output logic             err,
  output logic             locked
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [GOOD_W-1:0] GOOD_FULL = GOOD_W'(LOCK_COUNT);

  logic rise_s, fall_s, div_q_s;
  logic steady_hi_s, steady_lo_s, good_period_s;

  chk_state_t        state_q, state_d;
  logic [CNT_W-1:0]  hi_cnt_q, hi_cnt_d, lo_cnt_q, lo_cnt_d;
  logic              hi_ok_q, hi_ok_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_W:0]    period_q, period_d;
  logic              pv_q, pv_d, err_q, err_d, locked_q, locked_d;

  edge_detect_1b u_edge (
    .clk   (clk),
    .reset (reset),
    .d     (div_in),
    .rise  (rise_s),
    .fall  (fall_s),
    .d_q   (div_q_s)
  );

  assign steady_hi_s = div_in & div_q_s;
  assign steady_lo_s = ~div_in & ~div_q_s;

  // phase measurement FSM, period compare and lock counter
  always_comb begin
    state_d       = state_q;
    hi_cnt_d      = hi_cnt_q;
    lo_cnt_d      = lo_cnt_q;
    hi_ok_d       = hi_ok_q;
    good_cnt_d    = good_cnt_q;
    period_d      = period_q;
    pv_d          = 1'b0;
    err_d         = 1'b0;
    good_period_s = 1'b0;

    if (!en) begin
      state_d    = IDLE;
      hi_cnt_d   = '0;
      lo_cnt_d   = '0;
      hi_ok_d    = 1'b0;
      good_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise_s) begin
            state_d  = HIGH;
            hi_cnt_d = CNT_ONE;
          end else begin
            state_d = IDLE;
          end
        end
        HIGH: begin
          if (fall_s) begin
            state_d  = LOW;
            lo_cnt_d = CNT_ONE;
            hi_ok_d  = (hi_cnt_q == half_period);
            err_d    = (hi_cnt_q != half_period);
          end else if (steady_hi_s) begin
            // a stuck-high clock would otherwise wrap the counter silently
            if (hi_cnt_q == CNT_MAX) begin
              err_d    = 1'b1;
              state_d  = IDLE;
              hi_cnt_d = '0;
              lo_cnt_d = '0;
            end else begin
              hi_cnt_d = hi_cnt_q + CNT_ONE;
            end
          end else begin
            state_d = HIGH;
          end
        end
        LOW: begin
          if (rise_s) begin
            state_d       = HIGH;
            hi_cnt_d      = CNT_ONE;
            period_d      = {1'b0, hi_cnt_q} + {1'b0, lo_cnt_q};
            pv_d          = 1'b1;
            good_period_s = hi_ok_q && (lo_cnt_q == half_period);
            err_d         = ~good_period_s;
          end else if (steady_lo_s) begin
            if (lo_cnt_q == CNT_MAX) begin
              err_d    = 1'b1;
              state_d  = IDLE;
              hi_cnt_d = '0;
              lo_cnt_d = '0;
            end else begin
              lo_cnt_d = lo_cnt_q + CNT_ONE;
            end
          end else begin
            state_d = LOW;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (err_d) begin
        good_cnt_d = '0;
      end else if (good_period_s && (good_cnt_q != GOOD_FULL)) begin
        good_cnt_d = good_cnt_q + GOOD_W'(1);
      end else begin
        good_cnt_d = good_cnt_q;
      end
    end

    locked_d = (good_cnt_d == GOOD_FULL);
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      hi_cnt_q   <= '0;
      lo_cnt_q   <= '0;
      hi_ok_q    <= 1'b0;
      good_cnt_q <= '0;
      period_q   <= '0;
      pv_q       <= 1'b0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_cnt_q   <= hi_cnt_d;
      lo_cnt_q   <= lo_cnt_d;
      hi_ok_q    <= hi_ok_d;
      good_cnt_q <= good_cnt_d;
      period_q   <= period_d;
      pv_q       <= pv_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
    end
  end

  assign period_out   = period_q;
  assign period_valid = pv_q;
  assign err          = err_q;
  assign locked       = locked_q;

endmodule
